prio_code_fifo: RTL

- Downstream consumer of the 4-to-2 priority encoder (inputs d3..d0, outputs a, b, v).
- Captures each new encoded event ({a,b} while v=1) into a small synchronous FIFO.
- Presents captured codes to a slower consumer over a valid/ready handshake, so transient priority changes are not lost.
- Sits between the combinational encoder and the interrupt/service logic.

---
 rtl/prio_pkg.sv | 13 +
 rtl/prio_evt_detect.sv | 28 ++
 rtl/prio_code_fifo.sv | 87 ++++++++
 3 files changed

// File: rtl/prio_pkg.sv
// rtl/prio_pkg.sv - shared priority-code types and constants
package prio_pkg;

  localparam int CODE_W = 2;

  typedef logic [CODE_W-1:0] prio_code_t;

  localparam prio_code_t CODE_D0 = 2'b00;
  localparam prio_code_t CODE_D1 = 2'b01;
  localparam prio_code_t CODE_D2 = 2'b10;
  localparam prio_code_t CODE_D3 = 2'b11;

endpackage

// File: rtl/prio_evt_detect.sv
// rtl/prio_evt_detect.sv - flags a new encoder event: valid rising or code change while valid
module prio_evt_detect
  import prio_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enc_v,
  input  logic [CODE_W-1:0]      enc_code,
  output logic                   evt
);

  logic       prev_v;
  prio_code_t prev_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_v    <= 1'b0;
      prev_code <= CODE_D0;
    end else begin
      prev_v    <= enc_v;
      prev_code <= enc_code;
    end
  end

  // A steady code only counts once; the code is ignored entirely while invalid.
  assign evt = enc_v & (~prev_v | (enc_code != prev_code));

endmodule

// File: rtl/prio_code_fifo.sv
// rtl/prio_code_fifo.sv - captures encoder events into a small FIFO with a valid/ready drain
module prio_code_fifo
  import prio_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int CODE_W = prio_pkg::CODE_W,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enc_a,
  input  logic              enc_b,
  input  logic              enc_v,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = DEPTH;

  logic [CODE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CODE_W-1:0] enc_code;
  logic              evt;
  logic              pop;
  logic              do_push;
  logic              drop;

  assign enc_code = {enc_a, enc_b};

  prio_evt_detect u_evt_detect (
    .clk      (clk),
    .rst      (rst),
    .enc_v    (enc_v),
    .enc_code (enc_code),
    .evt      (evt)
  );

  assign out_valid = (count != '0);
  assign full      = (count == CNT_MAX);
  assign pop       = out_valid & out_ready;
  // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
  assign do_push   = evt & (~full | pop);
  assign drop      = evt & full & ~pop;
  assign out_code  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= enc_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (do_push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !do_push) begin
        count <= count - CNT_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
